// File: rtl/fetch_decode_queue.sv
// ---------------------------------------------------------------------------
// fetch_decode_queue
//
// Instruction queue between the fetch and decode stages. It buffers fetched
// instructions together with their pc and pcplus4, so that short decode
// stalls do not immediately stall cache access. The output is
// first-word-fall-through. A taken branch or jump (i_flush) discards the
// whole contents of the queue.
//
// Ports:
//   i_aclk          system clock
//   i_areset_n      asynchronous active-low reset
//   i_instr         instruction from fetch
//   i_instr_valid   i_instr / i_pc / i_pcplus4 are valid this cycle
//   i_pc            pc of i_instr
//   i_pcplus4       pc+4 of i_instr
//   o_fetch_en      enable to fetch; low = fetch holds its instruction
//   i_flush         branch/jump taken; drop all queued and incoming entries
//   i_decode_ready  decode consumes the head entry this cycle if o_valid
//   o_valid         head entry valid
//   o_instr         head instruction
//   o_pc            head pc
//   o_pcplus4       head pc+4
//   o_count         number of occupied entries
// ---------------------------------------------------------------------------
module fetch_decode_queue #(
    parameter int ADDR_SIZE = 32,
    parameter int INST_SIZE = 32,
    parameter int DEPTH     = 4
) (
    input  logic                     i_aclk,
    input  logic                     i_areset_n,
    input  logic [INST_SIZE-1:0]     i_instr,
    input  logic                     i_instr_valid,
    input  logic [ADDR_SIZE-1:0]     i_pc,
    input  logic [ADDR_SIZE-1:0]     i_pcplus4,
    output logic                     o_fetch_en,
    input  logic                     i_flush,
    input  logic                     i_decode_ready,
    output logic                     o_valid,
    output logic [INST_SIZE-1:0]     o_instr,
    output logic [ADDR_SIZE-1:0]     o_pc,
    output logic [ADDR_SIZE-1:0]     o_pcplus4,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INST_SIZE-1:0] instr_mem   [DEPTH];
    logic [ADDR_SIZE-1:0] pc_mem      [DEPTH];
    logic [ADDR_SIZE-1:0] pcplus4_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Forced high during a flush so fetch can load the branch target. Uses
    // only registered state and i_flush; a pop never frees a slot for the
    // same cycle, which keeps i_decode_ready off this path.
    assign o_fetch_en = ~full | i_flush;

    assign push = i_instr_valid & o_fetch_en & ~i_flush;
    assign pop  = o_valid & i_decode_ready & ~i_flush;

    assign o_valid   = ~empty;
    assign o_instr   = instr_mem[rd_ptr];
    assign o_pc      = pc_mem[rd_ptr];
    assign o_pcplus4 = pcplus4_mem[rd_ptr];
    assign o_count   = count;

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge i_aclk) begin
        if (push) begin
            instr_mem[wr_ptr]   <= i_instr;
            pc_mem[wr_ptr]      <= i_pc;
            pcplus4_mem[wr_ptr] <= i_pcplus4;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally; count tells
    // full from empty when the pointers are equal.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
module tb_fetch_decode_queue;

    localparam int ADDR_SIZE = 32;
    localparam int INST_SIZE = 32;
    localparam int DEPTH     = 4;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic                 i_aclk = 1'b0;
    logic                 i_areset_n = 1'b0;
    logic [INST_SIZE-1:0] i_instr = '0;
    logic                 i_instr_valid = 1'b0;
    logic [ADDR_SIZE-1:0] i_pc = '0;
    logic [ADDR_SIZE-1:0] i_pcplus4 = '0;
    logic                 o_fetch_en;
    logic                 i_flush = 1'b0;
    logic                 i_decode_ready = 1'b0;
    logic                 o_valid;
    logic [INST_SIZE-1:0] o_instr;
    logic [ADDR_SIZE-1:0] o_pc;
    logic [ADDR_SIZE-1:0] o_pcplus4;
    logic [CW-1:0]        o_count;

    fetch_decode_queue #(
        .ADDR_SIZE(ADDR_SIZE),
        .INST_SIZE(INST_SIZE),
        .DEPTH(DEPTH)
    ) dut (
        .i_aclk(i_aclk),
        .i_areset_n(i_areset_n),
        .i_instr(i_instr),
        .i_instr_valid(i_instr_valid),
        .i_pc(i_pc),
        .i_pcplus4(i_pcplus4),
        .o_fetch_en(o_fetch_en),
        .i_flush(i_flush),
        .i_decode_ready(i_decode_ready),
        .o_valid(o_valid),
        .o_instr(o_instr),
        .o_pc(o_pc),
        .o_pcplus4(o_pcplus4),
        .o_count(o_count)
    );

    always #5 i_aclk = ~i_aclk;

    typedef struct packed {
        logic [INST_SIZE-1:0] instr;
        logic [ADDR_SIZE-1:0] pc;
        logic [ADDR_SIZE-1:0] pcplus4;
    } entry_t;

    entry_t ref_q[$];
    int     errors = 0;
    int     checks = 0;
    logic [31:0] instr_salt = 32'h0000_0013;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Instruction word derived from pc, so a held instruction stays identical.
    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return (pc * 32'd3) ^ instr_salt;
    endfunction

    // Compare every visible output against the reference queue.
    task automatic check_outputs(input logic fl);
        int sz;
        sz = ref_q.size();
        check("count", 64'(o_count), 64'(sz));
        check("count_le_depth", 64'(o_count <= CW'(DEPTH)), 64'd1);
        check("valid", 64'(o_valid), 64'(sz != 0));
        check("fetch_en", 64'(o_fetch_en), 64'((sz != DEPTH) || fl));
        if (sz != 0) begin
            check("head_instr", 64'(o_instr), 64'(ref_q[0].instr));
            check("head_pc", 64'(o_pc), 64'(ref_q[0].pc));
            check("head_pcplus4", 64'(o_pcplus4), 64'(ref_q[0].pcplus4));
        end
    endtask

    // One clock cycle: entered just after a falling edge, returns at the next
    // falling edge. 'accepted' reports whether fetch's instruction was taken.
    task automatic step(input logic iv, input logic [31:0] pc, input logic rdy,
                        input logic fl, output logic accepted);
        int     sz;
        logic   do_pop;
        entry_t e;
        i_instr_valid  = iv;
        i_pc           = pc;
        i_pcplus4      = pc + 32'd4;
        i_instr        = instr_of(pc);
        i_decode_ready = rdy;
        i_flush        = fl;
        #1;
        check_outputs(fl);
        sz       = ref_q.size();
        accepted = iv && (sz != DEPTH) && !fl;
        do_pop   = (sz != 0) && rdy && !fl;
        @(posedge i_aclk);
        if (fl) begin
            ref_q.delete();
        end else begin
            if (do_pop) void'(ref_q.pop_front());
            if (accepted) begin
                e.instr   = instr_of(pc);
                e.pc      = pc;
                e.pcplus4 = pc + 32'd4;
                ref_q.push_back(e);
            end
        end
        @(negedge i_aclk);
    endtask

    initial begin
        logic        acc;
        logic        holding;
        logic        iv;
        logic        fl;
        logic [31:0] fpc;

        // Reset state
        repeat (2) @(negedge i_aclk);
        #1;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_fetch_en", 64'(o_fetch_en), 64'd1);
        @(negedge i_aclk);
        i_areset_n = 1'b1;

        // Fill without pop
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(4 * i), 1'b0, 1'b0, acc);
        #1;
        check("fill_count", 64'(o_count), 64'd4);
        check("fill_fetch_en", 64'(o_fetch_en), 64'd0);
        check("fill_pc", 64'(o_pc), 64'h0);
        check("fill_pcplus4", 64'(o_pcplus4), 64'h4);
        step(1'b1, 32'h10, 1'b0, 1'b0, acc);
        check("full_no_push", 64'(acc), 64'd0);
        check("full_count_held", 64'(o_count), 64'd4);

        // Drain
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            check("drain_pc", 64'(o_pc), 64'(4 * i));
            step(1'b0, 32'h0, 1'b1, 1'b0, acc);
            if (i == 0) check("drain_fetch_en_back", 64'(o_fetch_en), 64'd1);
        end
        check("drain_empty", 64'(o_valid), 64'd0);

        // Simultaneous push/pop at count 2
        step(1'b1, 32'h0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h4, 1'b0, 1'b0, acc);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("pp_pc_seq", 64'(o_pc), 64'(4 * i));
            step(1'b1, 32'(8 + 4 * i), 1'b1, 1'b0, acc);
            check("pp_count", 64'(o_count), 64'd2);
        end

        // Flush at count 3 with a same-cycle push and pop
        step(1'b1, 32'h30, 1'b0, 1'b0, acc);
        check("pre_flush_count", 64'(o_count), 64'd3);
        step(1'b1, 32'h34, 1'b1, 1'b1, acc);
        check("flush_valid", 64'(o_valid), 64'd0);
        check("flush_count", 64'(o_count), 64'd0);
        step(1'b1, 32'h100, 1'b0, 1'b0, acc);
        check("flush_target_pc", 64'(o_pc), 64'h100);

        // Reset mid-operation, asserted between edges
        step(1'b1, 32'h104, 1'b0, 1'b0, acc);
        check("pre_rst_count", 64'(o_count), 64'd2);
        i_instr_valid = 1'b0;
        @(posedge i_aclk);
        #2;
        i_areset_n = 1'b0;
        #1;
        check("midrst_valid", 64'(o_valid), 64'd0);
        check("midrst_count", 64'(o_count), 64'd0);
        check("midrst_fetch_en", 64'(o_fetch_en), 64'd1);
        ref_q.delete();
        @(negedge i_aclk);
        i_areset_n = 1'b1;
        step(1'b1, 32'h200, 1'b0, 1'b0, acc);
        check("post_rst_pc", 64'(o_pc), 64'h200);

        // Random stall stress with a fetch model that holds while stalled
        fpc     = 32'h1000;
        holding = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            iv = holding ? 1'b1 : ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 49) == 0);
            step(iv, fpc, 1'($urandom_range(0, 1)), fl, acc);
            if (fl) begin
                fpc        = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                instr_salt = $urandom;
                holding    = 1'b0;
            end else if (acc) begin
                fpc     = fpc + 32'd4;
                holding = 1'b0;
            end else if (iv) begin
                holding = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
